// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 4x4 keypad scanner.
// KEY_MAP translates a row-major scan index (row*4 + col) into the hex code
// printed on the Pmod KYPD key cap. lowest_set picks the next pending key.
package keypad_pkg;

  localparam int KEY_COLS = 4;
  localparam int KEY_ROWS = 4;
  localparam int KEY_NUM  = KEY_COLS * KEY_ROWS;

  // Row-major layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D (index 0 is rightmost)
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Index of the least significant set bit; returns 0 for an empty vector
  function automatic logic [3:0] lowest_set(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync2.sv
// key_sync2: two-flop synchroniser for the asynchronous row sense lines.
// Resets to RST_VAL so the idle (pulled-up) level is seen straight after reset.
module key_sync2 #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  // Two back-to-back flops to settle metastability on the raw pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces whole-frame snapshots
// and emits key events as hex codes over a valid/ready handshake.
// Optional feature macro: KEYPAD_RELEASE_EV_EN -- when defined, key releases
// are reported as events with key_release=1; otherwise only presses are
// reported and releases just update the debounced state.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 16384,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down
);

  localparam int                CNT_W    = $clog2(SCAN_CYCLES);
  localparam int                STB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(DEBOUNCE_SCANS - 1);

  // Scan timing
  logic [CNT_W-1:0] scan_cnt_reg, scan_cnt_next;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic             col_last;
  logic             frame_end;

  // Matrix snapshots and debounce
  logic [3:0]       row_sync;
  logic [15:0]      raw_reg;
  logic [15:0]      raw_frame;
  logic [15:0]      prev_raw_reg, prev_raw_next;
  logic [STB_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [15:0]      deb_reg, deb_next;
  logic             accept;
  logic [15:0]      press_mask;
  logic [15:0]      rel_mask;

  // Event emission
  logic [15:0]      pend_press_reg, pend_press_next;
  logic [15:0]      press_clr;
  logic [15:0]      press_after;
  logic [3:0]       press_idx;
  logic             slot_free;
  logic [3:0]       code_reg, code_next;
  logic             valid_reg, valid_next;

`ifdef KEYPAD_RELEASE_EV_EN
  logic [15:0]      pend_rel_reg, pend_rel_next;
  logic [15:0]      rel_clr;
  logic [15:0]      rel_after;
  logic [3:0]       rel_idx;
  logic             release_reg, release_next;
`endif

  key_sync2 #(
    .W       (KEY_ROWS),
    .RST_VAL ('1)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign col_last  = (scan_cnt_reg == CNT_LAST);
  assign frame_end = col_last && (col_idx_reg == 2'd3);

  // Snapshot of the matrix including the column being sampled this cycle,
  // so the frame-end comparison sees the complete frame.
  generate
    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_raw
      assign raw_frame[gi] = (col_last && (col_idx_reg == 2'(gi % KEY_COLS)))
                             ? ~row_sync[gi / KEY_COLS] : raw_reg[gi];
    end
  endgenerate

  // Column scan: counter wraps naturally because SCAN_CYCLES is a power of two
  always_comb begin
    scan_cnt_next = scan_cnt_reg + 1'b1;
    col_idx_next  = col_last ? col_idx_reg + 2'd1 : col_idx_reg;
  end

  // Frame-level debounce: accept a new matrix once it has been stable long enough
  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    prev_raw_next   = prev_raw_reg;
    deb_next        = deb_reg;
    accept          = 1'b0;
    if (frame_end) begin
      prev_raw_next = raw_frame;
      if (raw_frame == prev_raw_reg) begin
        stable_cnt_next = (stable_cnt_reg == STB_MAX) ? STB_MAX : stable_cnt_reg + 1'b1;
      end else begin
        stable_cnt_next = '0;
      end
      if ((stable_cnt_next == STB_MAX) && (raw_frame != deb_reg)) begin
        accept   = 1'b1;
        deb_next = raw_frame;
      end
    end
  end

  assign press_mask = raw_frame & ~deb_reg;
  assign rel_mask   = deb_reg & ~raw_frame;
  assign press_idx  = lowest_set(pend_press_reg);
  assign slot_free  = !valid_reg || key_ready;

`ifdef KEYPAD_RELEASE_EV_EN
  assign rel_idx = lowest_set(pend_rel_reg);
`endif

  // Output slot: load the next pending event whenever the slot is free
  always_comb begin
    valid_next = valid_reg;
    code_next  = code_reg;
    press_clr  = '0;
`ifdef KEYPAD_RELEASE_EV_EN
    release_next = release_reg;
    rel_clr      = '0;
`endif
    if (slot_free) begin
      if (|pend_press_reg) begin
        valid_next = 1'b1;
        code_next  = KEY_MAP[press_idx];
        press_clr  = 16'd1 << press_idx;
`ifdef KEYPAD_RELEASE_EV_EN
        release_next = 1'b0;
`endif
      end
`ifdef KEYPAD_RELEASE_EV_EN
      else if (|pend_rel_reg) begin
        valid_next   = 1'b1;
        code_next    = KEY_MAP[rel_idx];
        release_next = 1'b1;
        rel_clr      = 16'd1 << rel_idx;
      end
`endif
      else begin
        valid_next = 1'b0;
      end
    end
  end

  // Pending masks: emitted bits clear; an accepted frame adds presses and
  // cancels a press whose key was released before it could be reported.
  always_comb begin
    press_after     = pend_press_reg & ~press_clr;
    pend_press_next = press_after;
`ifdef KEYPAD_RELEASE_EV_EN
    rel_after     = pend_rel_reg & ~rel_clr;
    pend_rel_next = rel_after;
    if (accept) begin
      // A release still waiting when the key comes back cancels out with it
      pend_press_next = (press_after & ~rel_mask) | (press_mask & ~rel_after);
      pend_rel_next   = (rel_after & ~press_mask) | (rel_mask & ~press_after);
    end
`else
    if (accept) begin
      pend_press_next = (press_after & ~rel_mask) | press_mask;
    end
`endif
  end

  // State register for scan, debounce and emit logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg   <= '0;
      col_idx_reg    <= '0;
      raw_reg        <= '0;
      prev_raw_reg   <= '0;
      stable_cnt_reg <= '0;
      deb_reg        <= '0;
      pend_press_reg <= '0;
      code_reg       <= '0;
      valid_reg      <= 1'b0;
`ifdef KEYPAD_RELEASE_EV_EN
      pend_rel_reg   <= '0;
      release_reg    <= 1'b0;
`endif
    end else begin
      scan_cnt_reg   <= scan_cnt_next;
      col_idx_reg    <= col_idx_next;
      raw_reg        <= raw_frame;
      prev_raw_reg   <= prev_raw_next;
      stable_cnt_reg <= stable_cnt_next;
      deb_reg        <= deb_next;
      pend_press_reg <= pend_press_next;
      code_reg       <= code_next;
      valid_reg      <= valid_next;
`ifdef KEYPAD_RELEASE_EV_EN
      pend_rel_reg   <= pend_rel_next;
      release_reg    <= release_next;
`endif
    end
  end

  assign col       = ~(4'b0001 << col_idx_reg);
  assign key_code  = code_reg;
  assign key_valid = valid_reg;
  assign key_down  = |deb_reg;

`ifdef KEYPAD_RELEASE_EV_EN
  assign key_release = release_reg;
`else
  assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios against a 4x4 keypad matrix model.
// Expected events go into a queue as stimulus is applied; a negedge monitor
// pops and compares on every handshake transfer.
module tb_keypad_scanner;

  typedef struct packed {
    logic       rel;
    logic [3:0] code;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;

  logic [15:0] keys;
  ev_t         exp_q[$];
  ev_t         mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          last_xfer = 0;
  int          prev_xfer = 0;

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .key_code    (key_code),
    .key_release (key_release),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_down    (key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a pressed key shorts its row to its column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Monitor: every transfer must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      tests++;
      xfer_cnt++;
      prev_xfer = last_xfer;
      last_xfer = cyc;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event actual code=%h rel=%b required no event", key_code, key_release);
      end else begin
        mon_e = exp_q.pop_front();
        if ({key_release, key_code} !== mon_e) begin
          fails++;
          $display("FAIL event actual code=%h rel=%b required code=%h rel=%b",
                   key_code, key_release, mon_e.code, mon_e.rel);
        end else begin
          $display("[TB] event code=%h rel=%b at cycle %0d", key_code, key_release, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic rel, input logic [3:0] code);
    ev_t e;
    e.rel  = rel;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s timeout actual pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic release_all(input string name);
    keys = '0;
`ifdef KEYPAD_RELEASE_EV_EN
    for (int i = 0; i < 16; i++) begin
      if (pressed_snapshot[i]) push(1'b1, key_hex(i));
    end
    drain(name, 80);
`endif
    tick(64);
    check({name, "_key_down"}, 32'(key_down), 32'd0);
  endtask

  logic [15:0] pressed_snapshot;

  function automatic logic [3:0] key_hex(input int idx);
    logic [63:0] map;
    map = 64'hDEF0_C987_B654_A321;
    return map[idx*4 +: 4];
  endfunction

  initial begin
    int n;
    int n0;
    rst = 1'b1;
    keys = '0;
    key_ready = 1'b1;
    pressed_snapshot = '0;
    tick(3);

    // 1. reset state, column rotation, idle output
    check("rst_col", 32'(col), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("col_rotate", 32'(col), 32'(exp_col));
      tick(1);
    end
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (key_valid) n++;
      tick(1);
    end
    check("idle_valid_cycles", 32'(n), 32'd0);

    // 2. single press of '2'
    keys[1] = 1'b1;
    pressed_snapshot = keys;
    push(1'b0, 4'h2);
    drain("press2", 80);
    check("press2_key_down", 32'(key_down), 32'd1);
    release_all("rel2");

    // 3. backpressure holds the event, then exactly one transfer
    key_ready = 1'b0;
    keys[1] = 1'b1;
    pressed_snapshot = keys;
    push(1'b0, 4'h2);
    tick(100);
    check("bp_valid", 32'(key_valid), 32'd1);
    check("bp_code", 32'(key_code), 32'h2);
    check("bp_release", 32'(key_release), 32'd0);
    n0 = xfer_cnt;
    key_ready = 1'b1;
    drain("bp_drain", 10);
    tick(20);
    check("bp_one_xfer", 32'(xfer_cnt - n0), 32'd1);
    release_all("rel_bp");

    // 4. '1' and '5' together: ascending order, back-to-back
    keys = 16'h0021;
    pressed_snapshot = keys;
    push(1'b0, 4'h1);
    push(1'b0, 4'h5);
    drain("multi", 80);
    check("multi_consecutive", 32'(last_xfer - prev_xfer), 32'd1);
    release_all("rel_multi");

    // 5. '9' bouncing every frame is never accepted; then held
    for (int i = 0; i < 10; i++) begin
      keys[10] = ~keys[10];
      tick(16);
      check("bounce_key_down", 32'(key_down), 32'd0);
    end
    keys = '0;
    tick(48);
    keys[10] = 1'b1;
    pressed_snapshot = keys;
    push(1'b0, 4'h9);
    drain("hold9", 80);
    check("hold9_key_down", 32'(key_down), 32'd1);
    release_all("rel9");

    // 6. reset while an event is waiting, key still held
    key_ready = 1'b0;
    keys[1] = 1'b1;
    pressed_snapshot = keys;
    push(1'b0, 4'h2);
    n = 0;
    while (!key_valid && n < 100) begin
      tick(1);
      n++;
    end
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_code", 32'(key_code), 32'd0);
    check("mid_rst_key_down", 32'(key_down), 32'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    key_ready = 1'b1;
    push(1'b0, 4'h2);
    drain("rereport2", 80);
    release_all("rel_rst");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
